// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter, fetch sequencer and run control
module pc_fetch_ctrl #(
  parameter int D          = 12,
  parameter int START_ADDR = 0,
  parameter int MAX_CYCLES = 4096,
  parameter int CW         = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          branch_en,
  input  logic [D-1:0]  target,
  input  logic          stall,
  input  logic          halt,
  output logic [D-1:0]  prog_addr,
  output logic          running,
  output logic          Done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [D-1:0]  START_PC = D'(START_ADDR);
  // Last count value at which a RUN edge may still occur before the watchdog fires
  localparam logic [CW-1:0] WD_LAST  = CW'(MAX_CYCLES - 1);

  state_t state;

  // Run-control FSM with PC, cycle counter and registered status outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= S_IDLE;
      prog_addr   <= START_PC;
      running     <= 1'b0;
      Done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // Start from DONE is a full restart, identical to leaving IDLE
          if (Start) begin
            state       <= S_RUN;
            running     <= 1'b1;
            Done        <= 1'b0;
            prog_addr   <= START_PC;
            cycle_count <= '0;
            timeout     <= 1'b0;
          end
        end
        S_RUN: begin
          // Every RUN edge counts, including stalled, halting and timing-out ones
          cycle_count <= cycle_count + CW'(1);
          if (halt) begin
            state   <= S_DONE;
            running <= 1'b0;
            Done    <= 1'b1;
            timeout <= 1'b0;
          end else if (cycle_count == WD_LAST) begin
            state   <= S_DONE;
            running <= 1'b0;
            Done    <= 1'b1;
            timeout <= 1'b1;
          end else if (stall) begin
            prog_addr <= prog_addr;
          end else if (branch_en) begin
            prog_addr <= target;
          end else begin
            // Carry out of the top bit is dropped, so the PC wraps silently
            prog_addr <= prog_addr + D'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        branch_en = 1'b0;
  logic [11:0] target = 12'h000;
  logic        stall = 1'b0;
  logic        halt = 1'b0;

  logic [11:0] pa_a, pa_b;
  logic        run_a, run_b, done_a, done_b, to_a, to_b;
  logic [15:0] cc_a, cc_b;

  int n_vec = 0;
  int n_err = 0;

  // Main instance with the default watchdog budget
  pc_fetch_ctrl #(.D(12), .START_ADDR(0), .MAX_CYCLES(4096), .CW(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .branch_en(branch_en),
    .target(target), .stall(stall), .halt(halt),
    .prog_addr(pa_a), .running(run_a), .Done(done_a), .timeout(to_a),
    .cycle_count(cc_a)
  );

  // Short-watchdog instance sharing the same stimulus
  pc_fetch_ctrl #(.D(12), .START_ADDR(0), .MAX_CYCLES(8), .CW(16)) dut_wd (
    .Clk(Clk), .Reset(Reset), .Start(Start), .branch_en(branch_en),
    .target(target), .stall(stall), .halt(halt),
    .prog_addr(pa_b), .running(run_b), .Done(done_b), .timeout(to_b),
    .cycle_count(cc_b)
  );

  always #5 Clk = ~Clk;

  // Reference model: phase 0 idle, 1 running, 2 finished
  typedef struct {
    int phase;
    int pc;
    int cnt;
    int to;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.phase = 0; m.pc = 0; m.cnt = 0; m.to = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int maxc);
    mdl_t n = m;
    if (m.phase == 1) begin
      n.cnt = m.cnt + 1;
      if (halt) begin
        n.phase = 2; n.to = 0;
      end else if (m.cnt + 1 >= maxc) begin
        n.phase = 2; n.to = 1;
      end else if (stall) begin
        n.pc = m.pc;
      end else if (branch_en) begin
        n.pc = int'(target);
      end else begin
        n.pc = (m.pc + 1) % 4096;
      end
    end else if (Start) begin
      n.phase = 1; n.pc = 0; n.cnt = 0; n.to = 0;
    end
    return n;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model alongside the DUT, including async reset
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, 4096);
      mb = mdl_step(mb, 8);
    end
  end

  // Every-cycle comparison on the falling edge while out of reset
  always @(negedge Clk) begin
    if (Reset) begin
      cmp("a.prog_addr", int'(pa_a), ma.pc);
      cmp("a.running", int'(run_a), int'(ma.phase == 1));
      cmp("a.Done", int'(done_a), int'(ma.phase == 2));
      cmp("a.timeout", int'(to_a), ma.to);
      cmp("a.cycle_count", int'(cc_a), ma.cnt);
      cmp("b.prog_addr", int'(pa_b), mb.pc);
      cmp("b.running", int'(run_b), int'(mb.phase == 1));
      cmp("b.Done", int'(done_b), int'(mb.phase == 2));
      cmp("b.timeout", int'(to_b), mb.to);
      cmp("b.cycle_count", int'(cc_b), mb.cnt);
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    #3;
    cmp("rst.prog_addr", int'(pa_a), 0);
    cmp("rst.running", int'(run_a), 0);
    cmp("rst.Done", int'(done_a), 0);
    cmp("rst.timeout", int'(to_a), 0);
    cmp("rst.cycle_count", int'(cc_a), 0);
    cyc();
    Reset = 1'b1;
    cyc();

    // Straight-line run, halt while PC=5
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    cmp("t1.pc0", int'(pa_a), 0);
    cmp("t1.running", int'(run_a), 1);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      cmp("t1.pc_seq", int'(pa_a), i);
    end
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    cmp("t1.Done", int'(done_a), 1);
    cmp("t1.timeout", int'(to_a), 0);
    cmp("t1.cycle_count", int'(cc_a), 6);
    cmp("t1.pc_held", int'(pa_a), 5);
    cyc();
    cyc();
    cmp("t1.pc_frozen", int'(pa_a), 5);
    cmp("t1.Done_frozen", int'(done_a), 1);

    // Restart from DONE, branch at PC=3
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    cmp("t2.restart_cnt", int'(cc_a), 0);
    cmp("t2.restart_to", int'(to_a), 0);
    cmp("t2.restart_pc", int'(pa_a), 0);
    cyc(); cyc(); cyc();
    cmp("t2.pc3", int'(pa_a), 3);
    branch_en = 1'b1; target = 12'h0A0;
    cyc();
    branch_en = 1'b0;
    cmp("t2.branch", int'(pa_a), 12'h0A0);
    cyc();
    cmp("t2.after_branch", int'(pa_a), 12'h0A1);

    // Stall beats branch at PC=7
    branch_en = 1'b1; target = 12'h007;
    cyc();
    cmp("t3.pc7", int'(pa_a), 7);
    stall = 1'b1; target = 12'h055;
    cyc();
    stall = 1'b0;
    cmp("t3.stall_hold", int'(pa_a), 7);
    target = 12'h020;
    cyc();
    branch_en = 1'b0;
    cmp("t3.branch_after_stall", int'(pa_a), 12'h020);

    // Wrap from 0xFFF
    branch_en = 1'b1; target = 12'hFFF;
    cyc();
    branch_en = 1'b0;
    cmp("t4.pc_fff", int'(pa_a), 12'hFFF);
    cyc();
    cmp("t4.wrap", int'(pa_a), 0);
    cmp("t4.running", int'(run_a), 1);

    // Async reset mid-run at PC=0x040
    branch_en = 1'b1; target = 12'h040;
    cyc();
    branch_en = 1'b0;
    cmp("t5.pc40", int'(pa_a), 12'h040);
    #1 Reset = 1'b0;
    #1;
    cmp("t5.rst_pc", int'(pa_a), 0);
    cmp("t5.rst_running", int'(run_a), 0);
    cmp("t5.rst_Done", int'(done_a), 0);
    cyc();
    Reset = 1'b1;
    cyc();

    // Watchdog on the short-budget instance
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    cmp("t6.wd_running7", int'(run_b), 1);
    cyc();
    cmp("t6.wd_Done", int'(done_b), 1);
    cmp("t6.wd_timeout", int'(to_b), 1);
    cmp("t6.wd_cnt", int'(cc_b), 8);
    cmp("t6.wd_pc", int'(pa_b), 7);

    // Restart; halt on the 8th edge wins over the watchdog
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    cmp("t7.restart_cnt", int'(cc_b), 0);
    cmp("t7.restart_to", int'(to_b), 0);
    cmp("t7.main_ignores_start", int'(cc_a), 9);
    for (int i = 0; i < 7; i++) cyc();
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    cmp("t7.halt_Done", int'(done_b), 1);
    cmp("t7.halt_timeout", int'(to_b), 0);
    cmp("t7.halt_cnt", int'(cc_b), 8);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
